id_stage: RTL and testbench
===========================

# id_stage

Instruction-decode stage of the five-stage MIPS pipeline. It decodes the 32-bit word from IF/ID into the aluop/alusel encoding consumed by the execute stage, reads two register-file ports, and forwards in-flight results from EX and MEM. It applies MOVN/MOVZ conditions and registers the decoded bundle into the ID/EX pipeline register, with stall and flush control.

## Interface
- `ID_FORWARD_EN`: compile-time macro, undefined by default; see Configuration.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `inst_i` in 32: instruction from IF/ID.
- `stall_id_i` in 1: ID is stalled.
- `stall_ex_i` in 1: EX is stalled.
- `flush_i` in 1: discard the instruction in ID.
- `reg1_addr_o` out 5: regfile read address, rs (combinational).
- `reg2_addr_o` out 5: regfile read address, rt (combinational).
- `reg1_data_i` in 32: regfile read data for rs.
- `reg2_data_i` in 32: regfile read data for rt.
- `ex_wreg_i` in 1: EX-stage result write enable (forward source).
- `ex_wd_i` in 5: EX-stage destination register.
- `ex_wdata_i` in 32: EX-stage result data.
- `mem_wreg_i` in 1: MEM-stage result write enable (forward source).
- `mem_wd_i` in 5: MEM-stage destination register.
- `mem_wdata_i` in 32: MEM-stage result data.
- `aluop_o` out 8: registered; to EX.
- `alusel_o` out 3: registered; to EX.
- `reg1_o` out 32: registered; to EX.
- `reg2_o` out 32: registered; to EX.
- `wd_o` out 5: registered; to EX.
- `wreg_o` out 1: registered; to EX.
- `inst_invalid_o` out 1: registered; high when the word is not a supported opcode.

## Operation
- alusel values: NOP 000, LOGIC 001, SHIFT 010, MOVE 011.
- aluop values:
  - AND 00100100, OR 00100101, XOR 00100110, NOR 00100111.
  - SLL 01111100, SRL 00000010, SRA 00000011.
  - MOVZ 00001010, MOVN 00001011.
  - MFHI 00010000, MTHI 00010001, MFLO 00010010, MTLO 00010011.
  - NOP 00000000.
- SPECIAL (op 000000), destination rd:
  - funct 100100/100101/100110/100111 → AND/OR/XOR/NOR; reg1=rs, reg2=rt.
  - SLLV 000100, SRLV 000110, SRAV 000111: reg1=rs, reg2=rt.
  - SLL 000000, SRL 000010, SRA 000011 (rs field must be 0): reg1={27'b0,sa}, reg2=rt. The all-zero word decodes as SLL $0, a harmless NOP.
  - MOVZ 001010 / MOVN 001011: reg1=rs, reg2=rt. wreg=1 only when reg2 (after forwarding) ==0 for MOVZ, !=0 for MOVN.
  - MFHI/MFLO: wreg=1, rd; no register operands. MTHI/MTLO: reg1=rs, wreg=0.
- I-type, destination rt, reg2=imm:
  - ANDI 001100, ORI 001101, XORI 001110: imm zero-extended; reg1=rs.
  - LUI 001111: OR with reg1=0, reg2={imm,16'b0}.
- Operand source priority:
  - Register $0 always reads 32'h0 and is never forwarded.
  - Else EX match (`ex_wreg_i` && `ex_wd_i`==addr).
  - Else MEM match.
  - Else regfile data.
- Unsupported word: bundle is all-zero (NOP) and `inst_invalid_o`=1 for that slot.

## Timing
- Read addresses are combinational from `inst_i`. Bundle is visible on outputs one cycle after `inst_i` is presented.
- ID/EX update priority at each rising edge:
  1. `rst`: all outputs cleared to 0.
  2. `flush_i`: all outputs cleared (bubble), regardless of stalls.
  3. `stall_ex_i`: all outputs hold.
  4. `stall_id_i` (EX not stalled): insert bubble (all 0).
  5. Otherwise load the decoded bundle.
- Reset asserted mid-stream clears in the same edge; the first valid bundle appears one edge after `rst` falls.
- Forwarding is same-cycle combinational. No load-use interlock here; stall generation lives in the controller.

## Configuration
- `ID_FORWARD_EN` defined: EX/MEM forwarding as above.
- `ID_FORWARD_EN` undefined:
  - Operands come from regfile data only (with $0 forced to 0).
  - The ex_*/mem_* inputs are ignored.
  - Software must separate dependent instructions by 3 slots.

## Test plan
- ORI $1,$0,0x1100 (0x34011100) → next cycle aluop=00100101, alusel=001, reg1=0, reg2=0x00001100, wd=1, wreg=1.
- AND $3,$1,$2 with ex_wd=1, ex_wdata=0xFFFF0000, mem_wd=1, mem_wdata=0x1, reg1_data=0x5 → reg1_o=0xFFFF0000. Same with ex_wreg=0 → 0x1. With `ID_FORWARD_EN` undefined → 0x5.
- MOVN $4,$5,$6 with rt data 0 → wreg_o=0. With rt data 7 → wreg_o=1, aluop=00001011, reg1_o=rs data.
- SRA $7,$8,3 (0x000838C3) → aluop=00000011, alusel=010, reg1=3, reg2=$8 data, wd=7.
- Valid ADDI word → all-zero bundle, inst_invalid_o=1. stall_ex_i=1 for 2 cycles → outputs unchanged. stall_id_i only → bubble. flush_i with stall_ex_i → bubble.
- rst held 1 during a stream → all outputs 0 at the next edge. First bundle appears one edge after deassert.

Source files
------------

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module  : id_stage
// MIPS decode stage feeding the ID/EX register; EX/MEM forwarding when ID_FORWARD_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
module id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_i,
  input  logic        stall_id_i,
  input  logic        stall_ex_i,
  input  logic        flush_i,
  output logic [4:0]  reg1_addr_o,
  output logic [4:0]  reg2_addr_o,
  input  logic [31:0] reg1_data_i,
  input  logic [31:0] reg2_data_i,
  input  logic        ex_wreg_i,
  input  logic [4:0]  ex_wd_i,
  input  logic [31:0] ex_wdata_i,
  input  logic        mem_wreg_i,
  input  logic [4:0]  mem_wd_i,
  input  logic [31:0] mem_wdata_i,
  output logic [7:0]  aluop_o,
  output logic [2:0]  alusel_o,
  output logic [31:0] reg1_o,
  output logic [31:0] reg2_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic        inst_invalid_o
);

  localparam logic [2:0] c_SEL_NOP   = 3'b000;
  localparam logic [2:0] c_SEL_LOGIC = 3'b001;
  localparam logic [2:0] c_SEL_SHIFT = 3'b010;
  localparam logic [2:0] c_SEL_MOVE  = 3'b011;

  localparam logic [7:0] c_OP_NOP  = 8'b00000000;
  localparam logic [7:0] c_OP_AND  = 8'b00100100;
  localparam logic [7:0] c_OP_OR   = 8'b00100101;
  localparam logic [7:0] c_OP_XOR  = 8'b00100110;
  localparam logic [7:0] c_OP_NOR  = 8'b00100111;
  localparam logic [7:0] c_OP_SLL  = 8'b01111100;
  localparam logic [7:0] c_OP_SRL  = 8'b00000010;
  localparam logic [7:0] c_OP_SRA  = 8'b00000011;
  localparam logic [7:0] c_OP_MOVZ = 8'b00001010;
  localparam logic [7:0] c_OP_MOVN = 8'b00001011;
  localparam logic [7:0] c_OP_MFHI = 8'b00010000;
  localparam logic [7:0] c_OP_MTHI = 8'b00010001;
  localparam logic [7:0] c_OP_MFLO = 8'b00010010;
  localparam logic [7:0] c_OP_MTLO = 8'b00010011;

  localparam logic [5:0] c_OPC_SPECIAL = 6'b000000;
  localparam logic [5:0] c_OPC_ANDI    = 6'b001100;
  localparam logic [5:0] c_OPC_ORI     = 6'b001101;
  localparam logic [5:0] c_OPC_XORI    = 6'b001110;
  localparam logic [5:0] c_OPC_LUI     = 6'b001111;

  localparam logic [5:0] c_FN_SLL  = 6'b000000;
  localparam logic [5:0] c_FN_SRL  = 6'b000010;
  localparam logic [5:0] c_FN_SRA  = 6'b000011;
  localparam logic [5:0] c_FN_SLLV = 6'b000100;
  localparam logic [5:0] c_FN_SRLV = 6'b000110;
  localparam logic [5:0] c_FN_SRAV = 6'b000111;
  localparam logic [5:0] c_FN_MOVZ = 6'b001010;
  localparam logic [5:0] c_FN_MOVN = 6'b001011;
  localparam logic [5:0] c_FN_MFHI = 6'b010000;
  localparam logic [5:0] c_FN_MTHI = 6'b010001;
  localparam logic [5:0] c_FN_MFLO = 6'b010010;
  localparam logic [5:0] c_FN_MTLO = 6'b010011;
  localparam logic [5:0] c_FN_AND  = 6'b100100;
  localparam logic [5:0] c_FN_OR   = 6'b100101;
  localparam logic [5:0] c_FN_XOR  = 6'b100110;
  localparam logic [5:0] c_FN_NOR  = 6'b100111;

  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_sa;
  logic [15:0] w_imm;

  assign w_op    = inst_i[31:26];
  assign w_rs    = inst_i[25:21];
  assign w_rt    = inst_i[20:16];
  assign w_rd    = inst_i[15:11];
  assign w_sa    = inst_i[10:6];
  assign w_funct = inst_i[5:0];
  assign w_imm   = inst_i[15:0];

  assign reg1_addr_o = w_rs;
  assign reg2_addr_o = w_rt;

  logic [31:0] w_rs_val;
  logic [31:0] w_rt_val;

`ifdef ID_FORWARD_EN
  // The younger in-flight result (EX) wins over MEM; $0 is never forwarded.
  always_comb begin
    if (w_rs == 5'd0)                           w_rs_val = 32'h0;
    else if (ex_wreg_i && (ex_wd_i == w_rs))    w_rs_val = ex_wdata_i;
    else if (mem_wreg_i && (mem_wd_i == w_rs))  w_rs_val = mem_wdata_i;
    else                                        w_rs_val = reg1_data_i;
  end

  always_comb begin
    if (w_rt == 5'd0)                           w_rt_val = 32'h0;
    else if (ex_wreg_i && (ex_wd_i == w_rt))    w_rt_val = ex_wdata_i;
    else if (mem_wreg_i && (mem_wd_i == w_rt))  w_rt_val = mem_wdata_i;
    else                                        w_rt_val = reg2_data_i;
  end
`else
  assign w_rs_val = (w_rs == 5'd0) ? 32'h0 : reg1_data_i;
  assign w_rt_val = (w_rt == 5'd0) ? 32'h0 : reg2_data_i;

  logic w_unused_fwd;
  assign w_unused_fwd = ^{ex_wreg_i, ex_wd_i, ex_wdata_i, mem_wreg_i, mem_wd_i, mem_wdata_i};
`endif

  logic [7:0]  w_aluop;
  logic [2:0]  w_alusel;
  logic [31:0] w_reg1;
  logic [31:0] w_reg2;
  logic [4:0]  w_wd;
  logic        w_wreg;
  logic        w_invalid;

  always_comb begin
    w_aluop   = c_OP_NOP;
    w_alusel  = c_SEL_NOP;
    w_reg1    = 32'h0;
    w_reg2    = 32'h0;
    w_wd      = 5'd0;
    w_wreg    = 1'b0;
    w_invalid = 1'b0;
    case (w_op)
      c_OPC_SPECIAL: begin
        w_wd = w_rd;
        case (w_funct)
          c_FN_AND, c_FN_OR, c_FN_XOR, c_FN_NOR: begin
            w_alusel = c_SEL_LOGIC;
            w_reg1   = w_rs_val;
            w_reg2   = w_rt_val;
            w_wreg   = 1'b1;
            case (w_funct)
              c_FN_AND: w_aluop = c_OP_AND;
              c_FN_OR:  w_aluop = c_OP_OR;
              c_FN_XOR: w_aluop = c_OP_XOR;
              default:  w_aluop = c_OP_NOR;
            endcase
          end
          c_FN_SLLV, c_FN_SRLV, c_FN_SRAV: begin
            w_alusel = c_SEL_SHIFT;
            w_reg1   = w_rs_val;
            w_reg2   = w_rt_val;
            w_wreg   = 1'b1;
            w_aluop  = (w_funct == c_FN_SLLV) ? c_OP_SLL :
                       (w_funct == c_FN_SRLV) ? c_OP_SRL : c_OP_SRA;
          end
          c_FN_SLL, c_FN_SRL, c_FN_SRA: begin
            if (w_rs != 5'd0) begin
              w_invalid = 1'b1;
            end else begin
              w_alusel = c_SEL_SHIFT;
              w_reg1   = {27'b0, w_sa};
              w_reg2   = w_rt_val;
              w_wreg   = 1'b1;
              w_aluop  = (w_funct == c_FN_SLL) ? c_OP_SLL :
                         (w_funct == c_FN_SRL) ? c_OP_SRL : c_OP_SRA;
            end
          end
          c_FN_MOVZ, c_FN_MOVN: begin
            w_alusel = c_SEL_MOVE;
            w_reg1   = w_rs_val;
            w_reg2   = w_rt_val;
            w_aluop  = (w_funct == c_FN_MOVZ) ? c_OP_MOVZ : c_OP_MOVN;
            w_wreg   = (w_funct == c_FN_MOVZ) ? (w_rt_val == 32'h0) : (w_rt_val != 32'h0);
          end
          c_FN_MFHI, c_FN_MFLO: begin
            w_alusel = c_SEL_MOVE;
            w_wreg   = 1'b1;
            w_aluop  = (w_funct == c_FN_MFHI) ? c_OP_MFHI : c_OP_MFLO;
          end
          c_FN_MTHI, c_FN_MTLO: begin
            w_reg1  = w_rs_val;
            w_aluop = (w_funct == c_FN_MTHI) ? c_OP_MTHI : c_OP_MTLO;
          end
          default: w_invalid = 1'b1;
        endcase
      end
      c_OPC_ANDI, c_OPC_ORI, c_OPC_XORI: begin
        w_alusel = c_SEL_LOGIC;
        w_reg1   = w_rs_val;
        w_reg2   = {16'h0, w_imm};
        w_wd     = w_rt;
        w_wreg   = 1'b1;
        w_aluop  = (w_op == c_OPC_ANDI) ? c_OP_AND :
                   (w_op == c_OPC_ORI)  ? c_OP_OR  : c_OP_XOR;
      end
      c_OPC_LUI: begin
        w_alusel = c_SEL_LOGIC;
        w_aluop  = c_OP_OR;
        w_reg2   = {w_imm, 16'h0};
        w_wd     = w_rt;
        w_wreg   = 1'b1;
      end
      default: w_invalid = 1'b1;
    endcase
    // An unsupported word travels as a pure NOP so EX never sees partial fields.
    if (w_invalid) begin
      w_aluop  = c_OP_NOP;
      w_alusel = c_SEL_NOP;
      w_reg1   = 32'h0;
      w_reg2   = 32'h0;
      w_wd     = 5'd0;
      w_wreg   = 1'b0;
    end
  end

  logic [7:0]  r_aluop;
  logic [2:0]  r_alusel;
  logic [31:0] r_reg1;
  logic [31:0] r_reg2;
  logic [4:0]  r_wd;
  logic        r_wreg;
  logic        r_invalid;

  logic w_bubble;
  assign w_bubble = rst || flush_i || (stall_id_i && !stall_ex_i);

  always_ff @(posedge clk) begin
    if (w_bubble) begin
      r_aluop   <= c_OP_NOP;
      r_alusel  <= c_SEL_NOP;
      r_reg1    <= 32'h0;
      r_reg2    <= 32'h0;
      r_wd      <= 5'd0;
      r_wreg    <= 1'b0;
      r_invalid <= 1'b0;
    end else if (!stall_ex_i) begin
      r_aluop   <= w_aluop;
      r_alusel  <= w_alusel;
      r_reg1    <= w_reg1;
      r_reg2    <= w_reg2;
      r_wd      <= w_wd;
      r_wreg    <= w_wreg;
      r_invalid <= w_invalid;
    end
  end

  assign aluop_o        = r_aluop;
  assign alusel_o       = r_alusel;
  assign reg1_o         = r_reg1;
  assign reg2_o         = r_reg2;
  assign wd_o           = r_wd;
  assign wreg_o         = r_wreg;
  assign inst_invalid_o = r_invalid;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// Bench for id_stage: directed scenarios plus random instructions against a mnemonic-level model.
module tb_id_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall_id, stall_ex, flush;
  logic [31:0] inst, rd1, rd2, exd, memd;
  logic        exw, memw;
  logic [4:0]  exwd, memwd;
  logic [4:0]  a1, a2;
  logic [7:0]  aluop;
  logic [2:0]  alusel;
  logic [31:0] reg1, reg2;
  logic [4:0]  wd;
  logic        wreg, inv;

  id_stage dut (
    .clk(clk), .rst(rst), .inst_i(inst),
    .stall_id_i(stall_id), .stall_ex_i(stall_ex), .flush_i(flush),
    .reg1_addr_o(a1), .reg2_addr_o(a2),
    .reg1_data_i(rd1), .reg2_data_i(rd2),
    .ex_wreg_i(exw), .ex_wd_i(exwd), .ex_wdata_i(exd),
    .mem_wreg_i(memw), .mem_wd_i(memwd), .mem_wdata_i(memd),
    .aluop_o(aluop), .alusel_o(alusel), .reg1_o(reg1), .reg2_o(reg2),
    .wd_o(wd), .wreg_o(wreg), .inst_invalid_o(inv)
  );

  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  wd;
    logic        wreg;
    logic        inv;
  } bundle_t;

  bundle_t obs;
  assign obs = {aluop, alusel, reg1, reg2, wd, wreg, inv};

`ifdef ID_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam int K_AND = 0,  K_OR = 1,    K_XOR = 2,   K_NOR = 3,   K_SLLV = 4,  K_SRLV = 5;
  localparam int K_SRAV = 6, K_SLL = 7,   K_SRL = 8,   K_SRA = 9,   K_MOVZ = 10, K_MOVN = 11;
  localparam int K_MFHI = 12, K_MTHI = 13, K_MFLO = 14, K_MTLO = 15, K_ANDI = 16, K_ORI = 17;
  localparam int K_XORI = 18, K_LUI = 19, K_ADDI = 20, K_BADSH = 21, K_BADF = 22, K_NUM = 23;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [31:0] ORI_W = 32'h34011100;
  localparam logic [31:0] SRA_W = 32'h000838C3;
  localparam bundle_t ZERO_B = '0;
  localparam bundle_t ORI_B  = '{8'h25, 3'b001, 32'h0, 32'h00001100, 5'd1, 1'b1, 1'b0};

  // Value an operand should carry: $0 is zero, then EX, then MEM, then regfile.
  function automatic logic [31:0] opval(input logic [4:0] a, input logic [31:0] rf);
    if (a == 5'd0) return 32'h0;
    if (FWD && exw && exwd == a) return exd;
    if (FWD && memw && memwd == a) return memd;
    return rf;
  endfunction

  function automatic logic [31:0] enc(input int k, input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [4:0] sa, input logic [15:0] imm);
    logic [5:0] f;
    case (k)
      K_AND: f = 6'h24;  K_OR: f = 6'h25;   K_XOR: f = 6'h26;  K_NOR: f = 6'h27;
      K_SLLV: f = 6'h04; K_SRLV: f = 6'h06; K_SRAV: f = 6'h07;
      K_SRL: f = 6'h02;  K_SRA: f = 6'h03;  K_MOVZ: f = 6'h0A; K_MOVN: f = 6'h0B;
      K_MFHI: f = 6'h10; K_MTHI: f = 6'h11; K_MFLO: f = 6'h12; K_MTLO: f = 6'h13;
      K_BADF: f = 6'h20;
      default: f = 6'h00;
    endcase
    case (k)
      K_ANDI: return {6'b001100, rs, rt, imm};
      K_ORI:  return {6'b001101, rs, rt, imm};
      K_XORI: return {6'b001110, rs, rt, imm};
      K_LUI:  return {6'b001111, rs, rt, imm};
      K_ADDI: return {6'b001000, rs, rt, imm};
      default: return {6'b000000, rs, rt, rd, sa, f};
    endcase
  endfunction

  function automatic bundle_t model(input int k, input logic [4:0] rs, input logic [4:0] rt,
                                    input logic [4:0] rd, input logic [4:0] sa, input logic [15:0] imm);
    bundle_t b;
    logic [31:0] rsv, rtv;
    b = '0;
    rsv = opval(rs, rd1);
    rtv = opval(rt, rd2);
    case (k)
      K_AND, K_OR, K_XOR, K_NOR: begin
        b.aluop = (k == K_AND) ? 8'h24 : (k == K_OR) ? 8'h25 : (k == K_XOR) ? 8'h26 : 8'h27;
        b.alusel = 3'b001; b.reg1 = rsv; b.reg2 = rtv; b.wd = rd; b.wreg = 1'b1;
      end
      K_SLLV, K_SRLV, K_SRAV, K_SLL, K_SRL, K_SRA: begin
        b.aluop = (k == K_SLLV || k == K_SLL) ? 8'h7C : (k == K_SRLV || k == K_SRL) ? 8'h02 : 8'h03;
        b.alusel = 3'b010; b.reg2 = rtv; b.wd = rd; b.wreg = 1'b1;
        b.reg1 = (k == K_SLL || k == K_SRL || k == K_SRA) ? {27'b0, sa} : rsv;
      end
      K_MOVZ, K_MOVN: begin
        b.aluop = (k == K_MOVZ) ? 8'h0A : 8'h0B;
        b.alusel = 3'b011; b.reg1 = rsv; b.reg2 = rtv; b.wd = rd;
        b.wreg = (k == K_MOVZ) ? (rtv == 0) : (rtv != 0);
      end
      K_MFHI, K_MFLO: begin
        b.aluop = (k == K_MFHI) ? 8'h10 : 8'h12; b.alusel = 3'b011; b.wd = rd; b.wreg = 1'b1;
      end
      K_MTHI, K_MTLO: begin
        b.aluop = (k == K_MTHI) ? 8'h11 : 8'h13; b.reg1 = rsv; b.wd = rd;
      end
      K_ANDI, K_ORI, K_XORI: begin
        b.aluop = (k == K_ANDI) ? 8'h24 : (k == K_ORI) ? 8'h25 : 8'h26;
        b.alusel = 3'b001; b.reg1 = rsv; b.reg2 = {16'h0, imm}; b.wd = rt; b.wreg = 1'b1;
      end
      K_LUI: begin
        b.aluop = 8'h25; b.alusel = 3'b001; b.reg2 = {imm, 16'h0}; b.wd = rt; b.wreg = 1'b1;
      end
      default: b.inv = 1'b1;
    endcase
    return b;
  endfunction

  task automatic idle();
    rst = 1'b0; stall_id = 1'b0; stall_ex = 1'b0; flush = 1'b0;
    exw = 1'b0; exwd = 5'd0; exd = 32'h0; memw = 1'b0; memwd = 5'd0; memd = 32'h0;
    rd1 = 32'h0; rd2 = 32'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1; inst = ORI_W; rd2 = 32'h55;
    step(); step();
    n_checks++;
    if (obs !== ZERO_B) $display("FAIL reset bundle: got %h want %h", obs, ZERO_B); else n_pass++;
    n_checks++;
    if ({a1, a2} !== {5'd0, 5'd1}) $display("FAIL read addr: got %0d/%0d want 0/1", a1, a2); else n_pass++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_ori();
    @(negedge clk); idle(); inst = ORI_W;
    step();
    n_checks++;
    if (obs !== ORI_B) $display("FAIL ori bundle: got %h want %h", obs, ORI_B); else n_pass++;
  endtask

  task automatic test_forward();
    @(negedge clk); idle(); inst = 32'h00221824; rd1 = 32'h5; rd2 = 32'h22;
    exw = 1'b1; exwd = 5'd1; exd = 32'hFFFF0000; memw = 1'b1; memwd = 5'd1; memd = 32'h1;
    step();
    n_checks++;
    if (reg1 !== (FWD ? 32'hFFFF0000 : 32'h5))
      $display("FAIL fwd ex: got %h want %h", reg1, FWD ? 32'hFFFF0000 : 32'h5); else n_pass++;
    n_checks++;
    if ({aluop, wd, reg2} !== {8'h24, 5'd3, 32'h22})
      $display("FAIL and fields: got %h/%0d/%h want 24/3/22", aluop, wd, reg2); else n_pass++;
    @(negedge clk); exw = 1'b0;
    step();
    n_checks++;
    if (reg1 !== (FWD ? 32'h1 : 32'h5))
      $display("FAIL fwd mem: got %h want %h", reg1, FWD ? 32'h1 : 32'h5); else n_pass++;
  endtask

  task automatic test_movn();
    bundle_t e;
    @(negedge clk); idle(); inst = 32'h00A6200B; rd1 = 32'h1234; rd2 = 32'h0;
    step();
    e = '{8'h0B, 3'b011, 32'h1234, 32'h0, 5'd4, 1'b0, 1'b0};
    n_checks++;
    if (obs !== e) $display("FAIL movn zero: got %h want %h", obs, e); else n_pass++;
    @(negedge clk); rd2 = 32'h7;
    step();
    e = '{8'h0B, 3'b011, 32'h1234, 32'h7, 5'd4, 1'b1, 1'b0};
    n_checks++;
    if (obs !== e) $display("FAIL movn nonzero: got %h want %h", obs, e); else n_pass++;
  endtask

  task automatic test_sra();
    bundle_t e;
    @(negedge clk); idle(); inst = SRA_W; rd1 = 32'h99; rd2 = 32'hDEADBEEF;
    step();
    e = '{8'h03, 3'b010, 32'h3, 32'hDEADBEEF, 5'd7, 1'b1, 1'b0};
    n_checks++;
    if (obs !== e) $display("FAIL sra bundle: got %h want %h", obs, e); else n_pass++;
  endtask

  task automatic test_invalid();
    bundle_t e;
    @(negedge clk); idle(); inst = 32'h20010005; rd1 = 32'hAA;
    step();
    e = '{8'h0, 3'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1};
    n_checks++;
    if (obs !== e) $display("FAIL addi invalid: got %h want %h", obs, e); else n_pass++;
  endtask

  task automatic test_stall_flush();
    @(negedge clk); idle(); inst = ORI_W;
    step();
    @(negedge clk); stall_ex = 1'b1; inst = SRA_W; rd2 = 32'h1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (obs !== ORI_B) $display("FAIL stall_ex hold %0d: got %h want %h", i, obs, ORI_B); else n_pass++;
    end
    @(negedge clk); stall_ex = 1'b0; stall_id = 1'b1;
    step();
    n_checks++;
    if (obs !== ZERO_B) $display("FAIL stall_id bubble: got %h want %h", obs, ZERO_B); else n_pass++;
    @(negedge clk); stall_id = 1'b0; inst = ORI_W;
    step();
    @(negedge clk); flush = 1'b1; stall_ex = 1'b1;
    step();
    n_checks++;
    if (obs !== ZERO_B) $display("FAIL flush over stall: got %h want %h", obs, ZERO_B); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bundle_t e;
    @(negedge clk); idle(); inst = ORI_W;
    step();
    @(negedge clk); rst = 1'b1; inst = SRA_W; rd2 = 32'h0F0F0F0F;
    step();
    n_checks++;
    if (obs !== ZERO_B) $display("FAIL mid reset: got %h want %h", obs, ZERO_B); else n_pass++;
    step();
    @(negedge clk); rst = 1'b0;
    step();
    e = '{8'h03, 3'b010, 32'h3, 32'h0F0F0F0F, 5'd7, 1'b1, 1'b0};
    n_checks++;
    if (obs !== e) $display("FAIL first after reset: got %h want %h", obs, e); else n_pass++;
  endtask

  task automatic test_random(input int n);
    bundle_t exp_q, d;
    int k;
    logic [4:0] rs, rt, rd, sa;
    logic [15:0] imm;
    exp_q = obs === ZERO_B ? ZERO_B : ZERO_B;
    @(negedge clk); idle(); rst = 1'b1;
    step();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      k   = int'($urandom_range(0, K_NUM - 1));
      rs  = 5'($urandom); rd = 5'($urandom); sa = 5'($urandom); imm = 16'($urandom);
      rt  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      if (k == K_SLL || k == K_SRL || k == K_SRA || k == K_LUI) rs = 5'd0;
      if (k == K_BADSH && rs == 5'd0) rs = 5'd1;
      if (k == K_MFHI || k == K_MFLO) begin rs = 5'd0; rt = 5'd0; end
      if (k == K_MTHI || k == K_MTLO) begin rt = 5'd0; rd = 5'd0; end
      inst  = enc(k, rs, rt, rd, sa, imm);
      rd1   = $urandom; rd2 = $urandom; exd = $urandom; memd = $urandom;
      exw   = 1'($urandom_range(0, 1)); memw = 1'($urandom_range(0, 1));
      exwd  = ($urandom_range(0, 2) == 0) ? rs : ($urandom_range(0, 1) == 0) ? rt : 5'($urandom);
      memwd = ($urandom_range(0, 2) == 0) ? rs : ($urandom_range(0, 1) == 0) ? rt : 5'($urandom);
      if ($urandom_range(0, 3) == 0) begin rd2 = 32'h0; exd = 32'h0; memd = 32'h0; end
      rst      = ($urandom_range(0, 49) == 0);
      flush    = ($urandom_range(0, 19) == 0);
      stall_ex = ($urandom_range(0, 9) == 0);
      stall_id = ($urandom_range(0, 9) == 0);
      d = model(k, rs, rt, rd, sa, imm);
      if (rst || flush)   exp_q = ZERO_B;
      else if (stall_ex)  exp_q = exp_q;
      else if (stall_id)  exp_q = ZERO_B;
      else                exp_q = d;
      #1;
      n_checks++;
      if ({a1, a2} !== {rs, rt})
        $display("FAIL rand addr %0d: got %0d/%0d want %0d/%0d", i, a1, a2, rs, rt); else n_pass++;
      step();
      n_checks++;
      if (obs !== exp_q)
        $display("FAIL rand bundle %0d kind %0d inst %h: got %h want %h", i, k, inst, obs, exp_q);
      else n_pass++;
    end
  endtask

  initial begin
    inst = 32'h0;
    idle();
    test_reset();
    test_ori();
    test_forward();
    test_movn();
    test_sra();
    test_invalid();
    test_stall_flush();
    test_reset_mid();
    test_random(400);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
